// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: shared types and constants for the instruction fetch block.
//   fetch_state_e : fetch controller state (RUN, HALT)
//   INST_W        : instruction width in bits
//   PC_INC        : byte increment between sequential fetches
//   word_align()  : clears the byte-offset bits of a byte address
package inst_fetch_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

  localparam int unsigned INST_W = 32;
  localparam logic [31:0] PC_INC = 32'd4;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// inst_fetch_if: bundles the instruction-memory read port and the fetched
// instruction stream of inst_fetch.
//   imem_en / imem_addr / imem_dout     : synchronous memory read, data one cycle later
//   inst_valid / inst_ready / inst / inst_pc : valid/ready instruction stream
// Modports:
//   master : the fetch unit (drives memory requests and the instruction stream)
//   slave  : memory + downstream consumer
interface inst_fetch_if #(
  parameter int ADDR_W = 11
);
  import inst_fetch_pkg::*;

  logic              imem_en;
  logic [ADDR_W-1:0] imem_addr;
  logic [INST_W-1:0] imem_dout;

  logic              inst_valid;
  logic              inst_ready;
  logic [INST_W-1:0] inst;
  logic [31:0]       inst_pc;

  modport master (
    output imem_en,
    output imem_addr,
    input  imem_dout,
    output inst_valid,
    input  inst_ready,
    output inst,
    output inst_pc
  );

  modport slave (
    input  imem_en,
    input  imem_addr,
    output imem_dout,
    input  inst_valid,
    output inst_ready,
    input  inst,
    input  inst_pc
  );

endinterface

// File: rtl/inst_fetch.sv
// inst_fetch: sequential instruction fetch with redirect support.
//
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   fetch_en        : allow new sequential memory requests
//   bus (master)    : instruction-memory port and instruction stream (inst_fetch_if)
//   redirect_valid  : branch/jump redirect request
//   redirect_pc     : redirect target byte address
//   fetch_err       : sticky misaligned-redirect flag
//   fetch_count     : number of accepted instructions (wraps)
//
// Build option:
//   FETCH_ALIGN_CHECK_EN : when defined, a redirect to a non-word-aligned
//   target sets fetch_err and parks the block in HALT until reset. When not
//   defined, the low two redirect bits are ignored and HALT is never entered.
//
// State | meaning
// ------+-------------------------------------------------------------
// RUN   | normal fetching; sequential requests and redirects accepted
// HALT  | misaligned redirect seen; no requests, no output, until reset
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         fetch_en,
  inst_fetch_if.master bus,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_pc,
  output logic         fetch_err,
  output logic [31:0]  fetch_count
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         inst_valid_q, inst_valid_d;
  logic [31:0]  inst_pc_q, inst_pc_d;
  logic [31:0]  fetch_count_q, fetch_count_d;
`ifdef FETCH_ALIGN_CHECK_EN
  logic         fetch_err_q, fetch_err_d;
`endif

  logic         run;
  logic         redir;
  logic         redir_misaligned;
  logic         redir_ok;
  logic         seq_req;
  logic         req;
  logic [31:0]  req_pc;
  logic         valid_out;
  logic         accept;

  // rst_n gates the request path so the memory sees no read while reset is
  // held, even though fetch_en may already be high.
  always_comb begin
    run     = rst_n && (state_q == RUN);
    redir   = run && redirect_valid;
`ifdef FETCH_ALIGN_CHECK_EN
    redir_misaligned = redir && (redirect_pc[1:0] != 2'b00);
`else
    redir_misaligned = 1'b0;
`endif
    redir_ok = redir && !redir_misaligned;

    // Any redirect (aligned or not) kills the instruction currently on the
    // output so it cannot be accepted or counted.
    valid_out = inst_valid_q && !redir;
    accept    = valid_out && bus.inst_ready;

    seq_req = run && !redirect_valid && fetch_en && (!inst_valid_q || bus.inst_ready);
    req     = seq_req || redir_ok;
    req_pc  = redir_ok ? word_align(redirect_pc) : pc_q;
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inst_valid_d  = inst_valid_q;
    inst_pc_d     = inst_pc_q;
    fetch_count_d = fetch_count_q;
`ifdef FETCH_ALIGN_CHECK_EN
    fetch_err_d   = fetch_err_q;
`endif

    if (req) begin
      inst_pc_d    = req_pc;
      pc_d         = req_pc + PC_INC;
      inst_valid_d = 1'b1;
    end else if (accept || redir) begin
      inst_valid_d = 1'b0;
    end

    if (accept) begin
      fetch_count_d = fetch_count_q + 32'd1;
    end

`ifdef FETCH_ALIGN_CHECK_EN
    if (redir_misaligned) begin
      fetch_err_d = 1'b1;
      state_d     = HALT;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC;
      inst_valid_q  <= 1'b0;
      inst_pc_q     <= 32'h0000_0000;
      fetch_count_q <= 32'h0000_0000;
`ifdef FETCH_ALIGN_CHECK_EN
      fetch_err_q   <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inst_valid_q  <= inst_valid_d;
      inst_pc_q     <= inst_pc_d;
      fetch_count_q <= fetch_count_d;
`ifdef FETCH_ALIGN_CHECK_EN
      fetch_err_q   <= fetch_err_d;
`endif
    end
  end

  assign bus.imem_en    = req;
  assign bus.imem_addr  = req_pc[ADDR_W+1:2];
  assign bus.inst_valid = valid_out;
  assign bus.inst       = bus.imem_dout;
  assign bus.inst_pc    = inst_pc_q;
  assign fetch_count    = fetch_count_q;

`ifdef FETCH_ALIGN_CHECK_EN
  assign fetch_err = fetch_err_q;
`else
  assign fetch_err = 1'b0;
  // Byte-offset bits of the redirect target carry no meaning in this build.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];
`endif

endmodule
